// File: rtl/jtag_tap_controller.sv
// TAP controller: 16-state TAP FSM, instruction register, 1-bit bypass
// register and the negedge-registered TDO mux. The external data register
// is driven through capture_en/shift_en/update_en and read back on dr_tdo.
module jtag_tap_controller #(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] DR_INSTR    = 4'b0010,
  parameter logic [IR_WIDTH-1:0] RESET_INSTR = 4'b1111
) (
  input  logic                tclk,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                dr_tdo,
  output logic                capture_en,
  output logic                shift_en,
  output logic                update_en,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_active,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e          state_r;
  tap_state_e          state_next_s;
  logic [IR_WIDTH-1:0] ir_sr_r;
  logic [IR_WIDTH-1:0] ir_hold_r;
  logic                bypass_r;
  logic                tdo_r;
  logic                tdo_en_r;
  logic                sel_ext_s;

  // TAP next-state decode from tms
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TLR:     state_next_s = tms ? TLR    : RTI;
      RTI:     state_next_s = tms ? SEL_DR : RTI;
      SEL_DR:  state_next_s = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next_s = tms ? EX1_DR : SH_DR;
      SH_DR:   state_next_s = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next_s = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_next_s = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_next_s = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next_s = tms ? SEL_DR : RTI;
      SEL_IR:  state_next_s = tms ? TLR    : CAP_IR;
      CAP_IR:  state_next_s = tms ? EX1_IR : SH_IR;
      SH_IR:   state_next_s = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next_s = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_next_s = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_next_s = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next_s = tms ? SEL_DR : RTI;
      default: state_next_s = TLR;
    endcase
  end

  // TAP state register
  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      state_r <= TLR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // IR shift register: capture the fixed 01 pattern, then shift right from tdi
  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr_r <= '0;
    end else if (state_r == CAP_IR) begin
      ir_sr_r <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
    end else if (state_r == SH_IR) begin
      ir_sr_r <= {tdi, ir_sr_r[IR_WIDTH-1:1]};
    end else begin
      ir_sr_r <= ir_sr_r;
    end
  end

  // Held instruction: updated on the falling edge in UPD_IR, re-armed in TLR
  always_ff @(negedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      ir_hold_r <= RESET_INSTR;
    end else if (state_r == UPD_IR) begin
      ir_hold_r <= ir_sr_r;
    end else if (state_r == TLR) begin
      ir_hold_r <= RESET_INSTR;
    end else begin
      ir_hold_r <= ir_hold_r;
    end
  end

  // Active instruction: TLR overrides immediately on the edge that enters it
  always_comb begin
    if (state_r == TLR) begin
      ir_active = RESET_INSTR;
    end else begin
      ir_active = ir_hold_r;
    end
  end

  // Bypass register: only live when the external register is not selected
  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      bypass_r <= 1'b0;
    end else if ((state_r == CAP_DR) && !sel_ext_s) begin
      bypass_r <= 1'b0;
    end else if ((state_r == SH_DR) && !sel_ext_s) begin
      bypass_r <= tdi;
    end else begin
      bypass_r <= bypass_r;
    end
  end

  // TDO mux, launched on the falling edge so it is stable at the next rising edge
  always_ff @(negedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      tdo_r    <= 1'b0;
      tdo_en_r <= 1'b0;
    end else begin
      case (state_r)
        SH_IR: begin
          tdo_r    <= ir_sr_r[0];
          tdo_en_r <= 1'b1;
        end
        SH_DR: begin
          tdo_r    <= sel_ext_s ? dr_tdo : bypass_r;
          tdo_en_r <= 1'b1;
        end
        default: begin
          tdo_r    <= tdo_r;
          tdo_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Data-register enables decoded from the current state, gated by instruction
  always_comb begin
    sel_ext_s  = (ir_active == DR_INSTR);
    capture_en = (state_r == CAP_DR) && sel_ext_s;
    shift_en   = (state_r == SH_DR)  && sel_ext_s;
    update_en  = (state_r == UPD_DR) && sel_ext_s;
    tdo        = tdo_r;
    tdo_en     = tdo_en_r;
    tap_state  = state_r;
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller with a small 4-bit external
// data-register model attached to the enables and dr_tdo.
module tb_jtag_tap_controller;

  logic       tclk = 1'b0;
  logic       trst_n = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       dr_tdo;
  logic       capture_en, shift_en, update_en, tdo, tdo_en;
  logic [3:0] ir_active, tap_state;

  int         n_checks = 0;
  int         n_fail = 0;

  logic [3:0] dr_sr = 4'b0000;
  logic [3:0] dr_upd = 4'b0000;
  int         upd_count = 0;
  logic [3:0] pe_state, pe_ir;

  jtag_tap_controller dut (
    .tclk(tclk), .trst_n(trst_n), .tms(tms), .tdi(tdi), .dr_tdo(dr_tdo),
    .capture_en(capture_en), .shift_en(shift_en), .update_en(update_en),
    .tdo(tdo), .tdo_en(tdo_en), .ir_active(ir_active), .tap_state(tap_state)
  );

  always #5 tclk = ~tclk;

  // External data register model: captures 1101, shifts LSB first
  always @(posedge tclk) begin
    if (capture_en) dr_sr <= 4'b1101;
    else if (shift_en) dr_sr <= {tdi, dr_sr[3:1]};
  end
  assign dr_tdo = dr_sr[0];

  // Update stage of the model, on the falling edge
  always @(negedge tclk) begin
    if (update_en) begin
      dr_upd    <= dr_sr;
      upd_count <= upd_count + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One TCK: drive inputs, record state just after posedge, end just after negedge
  task automatic tick(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tclk);
    #1;
    pe_state = tap_state;
    pe_ir    = ir_active;
    @(negedge tclk);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] v);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    exp_seq[0] = 4'h7; exp_seq[1] = 4'h4;
    trst_n = 1'b0;
    tms = 1'b1;
    #12;
    n_checks++;
    if (tap_state !== 4'hF || ir_active !== 4'hF || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%h ir=%h tdo=%b en=%b, want F F 0 0", tap_state, ir_active, tdo, tdo_en);
    end
    n_checks++;
    if ({capture_en, shift_en, update_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_enables: got %b want 000", {capture_en, shift_en, update_en});
    end
    trst_n = 1'b1;
    tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hC || ir_active !== 4'hF || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_to_rti: state=%h ir=%h en=%b, want C F 0", tap_state, ir_active, tdo_en);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (tap_state !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL tms_ones_%0d: state=%h want %h", i, tap_state, exp_seq[i]);
      end
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_ir_scan();
    logic [3:0] bits;
    logic [3:0] exp_tdo;
    bits    = 4'b0010;
    exp_tdo = 4'b0001;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hE) begin
      n_fail++;
      $display("FAIL ir_capture_state: state=%h want E", tap_state);
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tap_state !== 4'hA || tdo !== exp_tdo[i] || tdo_en !== 1'b1) begin
        n_fail++;
        $display("FAIL ir_shift_tdo_%0d: state=%h tdo=%b en=%b, want A %b 1", i, tap_state, tdo, tdo_en, exp_tdo[i]);
      end
      tick(i == 3, bits[i]);
    end
    n_checks++;
    if (tap_state !== 4'h9 || tdo_en !== 1'b0 || ir_active !== 4'hF) begin
      n_fail++;
      $display("FAIL ir_exit1: state=%h en=%b ir=%h, want 9 0 F", tap_state, tdo_en, ir_active);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (pe_state !== 4'hD || pe_ir !== 4'hF) begin
      n_fail++;
      $display("FAIL ir_update_before_negedge: state=%h ir=%h, want D F", pe_state, pe_ir);
    end
    n_checks++;
    if (ir_active !== 4'b0010) begin
      n_fail++;
      $display("FAIL ir_update_value: ir=%h want 2", ir_active);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_dr_scan();
    logic [3:0] exp_tdo;
    logic [3:0] bits;
    int         base_upd;
    exp_tdo  = 4'b1101;
    bits     = 4'b0110;
    base_upd = upd_count;
    tick(1'b1, 1'b0);
    n_checks++;
    if (capture_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_sel_capture: got %b want 0", capture_en);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (capture_en !== 1'b1 || shift_en !== 1'b0 || tap_state !== 4'h6) begin
      n_fail++;
      $display("FAIL dr_capture: cap=%b sh=%b state=%h, want 1 0 6", capture_en, shift_en, tap_state);
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (capture_en !== 1'b0 || shift_en !== 1'b1 || update_en !== 1'b0 || tdo !== exp_tdo[i] || tdo_en !== 1'b1) begin
        n_fail++;
        $display("FAIL dr_shift_%0d: cap=%b sh=%b upd=%b tdo=%b en=%b, want 0 1 0 %b 1",
                 i, capture_en, shift_en, update_en, tdo, tdo_en, exp_tdo[i]);
      end
      tick(i == 3, bits[i]);
    end
    n_checks++;
    if (shift_en !== 1'b0 || tdo_en !== 1'b0 || tdo !== 1'b1 || update_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_exit1: sh=%b en=%b tdo=%b upd=%b, want 0 0 1 0", shift_en, tdo_en, tdo, update_en);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (update_en !== 1'b1 || tap_state !== 4'h5) begin
      n_fail++;
      $display("FAIL dr_update_en: upd=%b state=%h, want 1 5", update_en, tap_state);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (update_en !== 1'b0 || dr_upd !== 4'b0110 || upd_count !== base_upd + 1 || ir_active !== 4'b0010) begin
      n_fail++;
      $display("FAIL dr_update_result: upd=%b data=%h pulses=%0d ir=%h, want 0 6 %0d 2",
               update_en, dr_upd, upd_count - base_upd, ir_active, 1);
    end
  endtask

  task automatic test_pause();
    int base_upd;
    base_upd = upd_count;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (tdo !== 1'b0 || shift_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_pre_shift: tdo=%b sh=%b, want 0 1", tdo, shift_en);
    end
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (tap_state !== 4'h3 || shift_en !== 1'b0 || tdo_en !== 1'b0 || tdo !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold_%0d: state=%h sh=%b en=%b tdo=%b, want 3 0 0 0", i, tap_state, shift_en, tdo_en, tdo);
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'h2 || shift_en !== 1'b1 || tdo !== 1'b1 || tdo_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume: state=%h sh=%b tdo=%b en=%b, want 2 1 1 1", tap_state, shift_en, tdo, tdo_en);
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (dr_upd !== 4'b0010 || upd_count !== base_upd + 1) begin
      n_fail++;
      $display("FAIL pause_no_bit_loss: data=%h pulses=%0d, want 2 1", dr_upd, upd_count - base_upd);
    end
  endtask

  task automatic test_tlr_entry();
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    n_checks++;
    if (ir_active !== 4'b0010) begin
      n_fail++;
      $display("FAIL tlr_before: ir=%h want 2", ir_active);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (pe_state !== 4'hF || pe_ir !== 4'hF) begin
      n_fail++;
      $display("FAIL tlr_entry_edge: state=%h ir=%h, want F F", pe_state, pe_ir);
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hC || ir_active !== 4'hF) begin
      n_fail++;
      $display("FAIL tlr_exit: state=%h ir=%h, want C F", tap_state, ir_active);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] bits;
    int         base_upd;
    bits     = 4'b1101;
    base_upd = upd_count;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    n_checks++;
    if (capture_en !== 1'b0 || tap_state !== 4'h6) begin
      n_fail++;
      $display("FAIL byp_capture: cap=%b state=%h, want 0 6", capture_en, tap_state);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (tdo !== 1'b0 || tdo_en !== 1'b1 || shift_en !== 1'b0) begin
      n_fail++;
      $display("FAIL byp_captured_bit: tdo=%b en=%b sh=%b, want 0 1 0", tdo, tdo_en, shift_en);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, bits[i]);
      if (i < 3) begin
        n_checks++;
        if (tdo !== bits[i] || tdo_en !== 1'b1 || shift_en !== 1'b0) begin
          n_fail++;
          $display("FAIL byp_shift_%0d: tdo=%b en=%b sh=%b, want %b 1 0", i, tdo, tdo_en, shift_en, bits[i]);
        end
      end
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (update_en !== 1'b0 || tap_state !== 4'h5) begin
      n_fail++;
      $display("FAIL byp_update: upd=%b state=%h, want 0 5", update_en, tap_state);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (upd_count !== base_upd) begin
      n_fail++;
      $display("FAIL byp_no_update: pulses=%0d want 0", upd_count - base_upd);
    end
  endtask

  task automatic test_reset_mid_scan();
    int base_upd;
    load_ir(4'b0010);
    base_upd = upd_count;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    n_checks++;
    if (tap_state !== 4'hA || ir_active !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_scan_setup: state=%h ir=%h, want A 2", tap_state, ir_active);
    end
    trst_n = 1'b0;
    #1;
    n_checks++;
    if (tap_state !== 4'hF || ir_active !== 4'hF || tdo !== 1'b0 || tdo_en !== 1'b0 || update_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_scan_async_reset: state=%h ir=%h tdo=%b en=%b upd=%b, want F F 0 0 0",
               tap_state, ir_active, tdo, tdo_en, update_en);
    end
    #1;
    trst_n = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hC || ir_active !== 4'hF || upd_count !== base_upd) begin
      n_fail++;
      $display("FAIL mid_scan_after: state=%h ir=%h pulses=%0d, want C F 0", tap_state, ir_active, upd_count - base_upd);
    end
  endtask

  initial begin
    test_reset();
    test_ir_scan();
    test_dr_scan();
    test_pause();
    test_tlr_entry();
    test_bypass();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
